// File: rtl/mult_acc_stream.sv
// Block accumulator: sums BLOCK_LEN unsigned products into 16 bits and streams the result out low byte first.
// Optional feature macro MULT_ACC_PEAK_EN adds a per-block peak register and a third emitted byte.
module mult_acc_stream #(
  parameter int BLOCK_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_prod_valid,
  input  logic [7:0] i_prod_data,
  output logic       o_prod_ready,
  input  logic       i_clear,
  output logic       o_res_valid,
  output logic [7:0] o_res_data,
  input  logic       i_res_ready
);

  localparam logic [7:0] LP_BLOCK_LEN = 8'(BLOCK_LEN);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_EMIT_LO = 2'd1,
`ifdef MULT_ACC_PEAK_EN
    ST_EMIT_HI = 2'd2,
    ST_EMIT_PK = 2'd3
`else
    ST_EMIT_HI = 2'd2
`endif
  } state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [7:0]  r_cnt;
  logic        r_prod_ready;
  logic        r_res_valid;
  logic [7:0]  r_res_data;

  logic        w_accept;
  logic [15:0] w_acc_sum;
  logic [7:0]  w_cnt_inc;
  logic        w_last;

`ifdef MULT_ACC_PEAK_EN
  logic [7:0]  r_peak;
  logic [7:0]  w_peak_next;

  // Running maximum including the product offered this cycle.
  always_comb begin
    w_peak_next = r_peak;
    if (i_prod_data > r_peak) begin
      w_peak_next = i_prod_data;
    end else begin
      w_peak_next = r_peak;
    end
  end
`endif

  // Accept qualification and next-value arithmetic for the accumulate path.
  always_comb begin
    w_accept  = i_prod_valid & r_prod_ready;
    w_acc_sum = r_acc + {8'd0, i_prod_data};
    w_cnt_inc = r_cnt + 8'd1;
    w_last    = (w_cnt_inc == LP_BLOCK_LEN);
  end

  // Control FSM with datapath registers; outputs are registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_ACCUM;
      r_acc        <= 16'd0;
      r_cnt        <= 8'd0;
      r_prod_ready <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_data   <= 8'd0;
`ifdef MULT_ACC_PEAK_EN
      r_peak       <= 8'd0;
`endif
    end else if (i_clear) begin
      // Abort wins over any handshake offered in the same cycle.
      r_state      <= ST_ACCUM;
      r_acc        <= 16'd0;
      r_cnt        <= 8'd0;
      r_prod_ready <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_data   <= 8'd0;
`ifdef MULT_ACC_PEAK_EN
      r_peak       <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_sum;
            r_cnt <= w_cnt_inc;
`ifdef MULT_ACC_PEAK_EN
            r_peak <= w_peak_next;
`endif
            if (w_last) begin
              r_state      <= ST_EMIT_LO;
              r_prod_ready <= 1'b0;
              r_res_valid  <= 1'b1;
              r_res_data   <= w_acc_sum[7:0];
            end
          end
        end
        ST_EMIT_LO: begin
          if (i_res_ready) begin
            r_state    <= ST_EMIT_HI;
            r_res_data <= r_acc[15:8];
          end
        end
        ST_EMIT_HI: begin
          if (i_res_ready) begin
`ifdef MULT_ACC_PEAK_EN
            r_state    <= ST_EMIT_PK;
            r_res_data <= r_peak;
`else
            r_state      <= ST_ACCUM;
            r_acc        <= 16'd0;
            r_cnt        <= 8'd0;
            r_prod_ready <= 1'b1;
            r_res_valid  <= 1'b0;
            r_res_data   <= 8'd0;
`endif
          end
        end
`ifdef MULT_ACC_PEAK_EN
        ST_EMIT_PK: begin
          if (i_res_ready) begin
            r_state      <= ST_ACCUM;
            r_acc        <= 16'd0;
            r_cnt        <= 8'd0;
            r_peak       <= 8'd0;
            r_prod_ready <= 1'b1;
            r_res_valid  <= 1'b0;
            r_res_data   <= 8'd0;
          end
        end
`endif
        default: begin
          r_state      <= ST_ACCUM;
          r_acc        <= 16'd0;
          r_cnt        <= 8'd0;
          r_prod_ready <= 1'b1;
          r_res_valid  <= 1'b0;
          r_res_data   <= 8'd0;
`ifdef MULT_ACC_PEAK_EN
          r_peak       <= 8'd0;
`endif
        end
      endcase
    end
  end

  assign o_prod_ready = r_prod_ready;
  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;

endmodule

// File: tb/tb_mult_acc_stream.sv
// Directed self-checking bench for mult_acc_stream: one instance with BLOCK_LEN=4, one with BLOCK_LEN=1.
module tb_mult_acc_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_prod_valid = 1'b0;
  logic [7:0] a_prod_data = 8'd0;
  logic       a_prod_ready;
  logic       a_clear = 1'b0;
  logic       a_res_valid;
  logic [7:0] a_res_data;
  logic       a_res_ready = 1'b1;

  logic       b_prod_valid = 1'b0;
  logic [7:0] b_prod_data = 8'd0;
  logic       b_prod_ready;
  logic       b_clear = 1'b0;
  logic       b_res_valid;
  logic [7:0] b_res_data;
  logic       b_res_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mult_acc_stream #(.BLOCK_LEN(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_prod_valid(a_prod_valid), .i_prod_data(a_prod_data), .o_prod_ready(a_prod_ready),
    .i_clear(a_clear),
    .o_res_valid(a_res_valid), .o_res_data(a_res_data), .i_res_ready(a_res_ready)
  );

  mult_acc_stream #(.BLOCK_LEN(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_prod_valid(b_prod_valid), .i_prod_data(b_prod_data), .o_prod_ready(b_prod_ready),
    .i_clear(b_clear),
    .o_res_valid(b_res_valid), .o_res_data(b_res_data), .i_res_ready(b_res_ready)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_prod_valid = 1'b1;
    a_prod_data  = d;
    step();
    a_prod_valid = 1'b0;
    a_prod_data  = 8'd0;
  endtask

  task automatic a_expect(input string tag, input logic v, input logic [7:0] d, input logic r);
    check({tag, ".valid"}, 16'(a_res_valid), 16'(v));
    check({tag, ".data"},  16'(a_res_data),  16'(d));
    check({tag, ".ready"}, 16'(a_prod_ready), 16'(r));
  endtask

  task automatic b_expect(input string tag, input logic v, input logic [7:0] d, input logic r);
    check({tag, ".valid"}, 16'(b_res_valid), 16'(v));
    check({tag, ".data"},  16'(b_res_data),  16'(d));
    check({tag, ".ready"}, 16'(b_prod_ready), 16'(r));
  endtask

  initial begin
    // Reset state
    step();
    a_expect("rst_hold", 1'b0, 8'h00, 1'b1);
    b_expect("rst_hold_b", 1'b0, 8'h00, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    a_expect("rst_rel", 1'b0, 8'h00, 1'b1);

    // 4 x 225 = 0x0384, full-rate drain
    for (int i = 0; i < 4; i++) a_push(8'd225);
    a_expect("full_lo", 1'b1, 8'h84, 1'b0);
    step();
    a_expect("full_hi", 1'b1, 8'h03, 1'b0);
    step();
`ifdef MULT_ACC_PEAK_EN
    a_expect("full_pk", 1'b1, 8'hE1, 1'b0);
    step();
`endif
    a_expect("full_back", 1'b0, 8'h00, 1'b1);

    // Backpressure in EMIT_LO
    a_res_ready = 1'b0;
    for (int i = 0; i < 4; i++) a_push(8'd225);
    for (int i = 0; i < 3; i++) begin
      a_expect("stall_lo", 1'b1, 8'h84, 1'b0);
      if (i < 2) step();
    end
    a_res_ready = 1'b1;
    a_expect("stall_rel", 1'b1, 8'h84, 1'b0);
    step();
    a_expect("stall_hi", 1'b1, 8'h03, 1'b0);
    step();
`ifdef MULT_ACC_PEAK_EN
    step();
`endif
    a_expect("stall_back", 1'b0, 8'h00, 1'b1);

    // Clear coincident with an offered product
    a_push(8'd10);
    a_push(8'd20);
    a_clear = 1'b1;
    a_push(8'd30);
    a_clear = 1'b0;
    a_expect("clr_acc", 1'b0, 8'h00, 1'b1);
    a_push(8'd1);
    a_push(8'd2);
    a_push(8'd3);
    a_expect("clr_cnt", 1'b0, 8'h00, 1'b1);
    a_push(8'd4);
    a_expect("clr_lo", 1'b1, 8'h0A, 1'b0);
    step();
    a_expect("clr_hi", 1'b1, 8'h00, 1'b0);
    step();
`ifdef MULT_ACC_PEAK_EN
    a_expect("clr_pk", 1'b1, 8'h04, 1'b0);
    step();
`endif
    a_expect("clr_back", 1'b0, 8'h00, 1'b1);

    // Clear during an emit with res_ready high drops the byte
    a_res_ready = 1'b0;
    for (int i = 0; i < 4; i++) a_push(8'd50);
    a_expect("clre_lo", 1'b1, 8'hC8, 1'b0);
    a_clear = 1'b1;
    a_res_ready = 1'b1;
    step();
    a_clear = 1'b0;
    a_expect("clre_abort", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset during EMIT_HI
    for (int i = 0; i < 4; i++) a_push(8'd100);
    a_expect("arst_lo", 1'b1, 8'h90, 1'b0);
    step();
    a_expect("arst_hi", 1'b1, 8'h01, 1'b0);
    a_res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    a_expect("arst_async", 1'b0, 8'h00, 1'b1);
    #1;
    rst_n = 1'b1;
    a_res_ready = 1'b1;
    for (int i = 0; i < 4; i++) a_push(8'd1);
    a_expect("arst_nlo", 1'b1, 8'h04, 1'b0);
    step();
    a_expect("arst_nhi", 1'b1, 8'h00, 1'b0);
    step();
`ifdef MULT_ACC_PEAK_EN
    a_expect("arst_npk", 1'b1, 8'h01, 1'b0);
    step();
`endif
    a_expect("arst_back", 1'b0, 8'h00, 1'b1);

    // Peak byte presence depends on the build
    a_push(8'd3);
    a_push(8'd200);
    a_push(8'd17);
    a_push(8'd9);
    a_expect("pk_lo", 1'b1, 8'hE5, 1'b0);
    step();
    a_expect("pk_hi", 1'b1, 8'h00, 1'b0);
    step();
`ifdef MULT_ACC_PEAK_EN
    a_expect("pk_pk", 1'b1, 8'hC8, 1'b0);
    step();
`endif
    a_expect("pk_end", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a_push(8'd1);
      a_expect("pk_nov", 1'b0, 8'h00, 1'b1);
    end
    a_push(8'd1);
    a_expect("pk_next", 1'b1, 8'h04, 1'b0);
    step();
    step();
`ifdef MULT_ACC_PEAK_EN
    step();
`endif

    // BLOCK_LEN=1: every product emits
    for (int k = 0; k < 2; k++) begin
      logic [7:0] v;
      v = (k == 0) ? 8'd5 : 8'd7;
      b_prod_valid = 1'b1;
      b_prod_data  = v;
      step();
      b_prod_valid = 1'b0;
      b_prod_data  = 8'd0;
      b_expect("b1_lo", 1'b1, v, 1'b0);
      step();
      b_expect("b1_hi", 1'b1, 8'h00, 1'b0);
      step();
`ifdef MULT_ACC_PEAK_EN
      b_expect("b1_pk", 1'b1, v, 1'b0);
      step();
`endif
      b_expect("b1_back", 1'b0, 8'h00, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_acc_stream.md
# mult_acc_stream

Downstream consumer of the 4x4 array multiplier's 8-bit product. Accepts a stream of unsigned products over a valid/ready handshake and sums each block of BLOCK_LEN products into a 16-bit accumulator. It then emits the block result as a byte stream, low byte first, over a second valid/ready handshake. It is the accumulate-and-serialize stage between the multiplier and the output pins.

## Interface
- BLOCK_LEN, 4: products per accumulation block; legal range 1..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- prod_valid  input  1  prod_data is valid this cycle.
- prod_data  input  8  unsigned product; max legal value 225.
- prod_ready  output  1  block can accept a product this cycle.
- clear  input  1  synchronous abort; discards the current block.
- res_valid  output  1  res_data is valid this cycle.
- res_data  output  8  result byte.
- res_ready  input  1  downstream takes res_data this cycle.

## Operation
- States:
  - ACCUM: prod_ready=1, res_valid=0.
  - EMIT_LO: res_data=acc[7:0].
  - EMIT_HI: res_data=acc[15:8].
  - EMIT_PK: only with the macro; res_data=peak.
- Registers:
  - acc: 16 bit.
  - cnt: 8 bit, counts accepted products in the current block.
  - peak: 8 bit, only with the macro.
- Accept means prod_valid & prod_ready at a rising edge. On accept: acc <= acc + prod_data (zero-extended) and cnt <= cnt + 1.
- The accept that makes cnt reach BLOCK_LEN moves the FSM ACCUM -> EMIT_LO.
- EMIT_LO -> EMIT_HI on res_ready.
- EMIT_HI on res_ready:
  - With the macro: -> EMIT_PK.
  - Without the macro: -> ACCUM, with acc, cnt and peak cleared.
- EMIT_PK -> ACCUM on res_ready, with acc, cnt and peak cleared.
- Overflow cannot occur: 225*255 = 57375 < 2^16. No saturation logic.
- Outputs are decoded from registered state only; no combinational path from any input to any output.
- res_data = 0 whenever res_valid = 0.
- clear = 1 at an edge, in any state:
  - acc, cnt, peak <= 0 and state <= ACCUM.
  - Overrides a simultaneous accept or emit handshake. The product or byte offered that cycle is dropped and is not consumed.
- prod_data > 225 is out of contract; the sum wraps modulo 2^16 and no flag is raised.

## Timing
- Reset values (rst_n low, and after release): state ACCUM, acc 0, cnt 0, peak 0, prod_ready 1, res_valid 0, res_data 0.
- Reset mid-block or mid-emit abandons all data immediately, asynchronously.
- Throughput in ACCUM: one product per cycle.
- Latency: if the last product of a block is accepted at edge N, res_valid=1 with the low byte from edge N through at least edge N+1.
- Minimum cycles per block: BLOCK_LEN + 2 (BLOCK_LEN + 3 with the macro), at full res_ready.
- prod_ready=0 during all EMIT states, so upstream stalls.
- res_data and res_valid hold stable while res_ready=0 (no retraction).
- BLOCK_LEN=1: every accepted product triggers an emit.

## Configuration
- MULT_ACC_PEAK_EN defined:
  - peak <= max(peak, prod_data) on each accept.
  - Each block emits a third byte (peak) after the high byte.
- MULT_ACC_PEAK_EN undefined: no peak register and no EMIT_PK state; each block emits exactly two bytes.

## Test plan
- Reset, BLOCK_LEN=4, res_ready=1, products 225,225,225,225 back-to-back -> bytes 0x84 then 0x03 on consecutive cycles, and prod_ready returns to 1 the cycle after the 0x03 transfer.
- Same stream with res_ready held low for 3 cycles in EMIT_LO -> res_data stays 0x84 with res_valid=1 and prod_ready=0 throughout, then 0x84, 0x03 are delivered.
- Products 10,20, then clear=1 coincident with prod_valid carrying 30, then 1,2,3,4 -> single result 0x000A (bytes 0x0A, 0x00); the 30 is not counted.
- rst_n pulsed low during EMIT_HI of block 100,100,100,100 -> res_valid drops asynchronously, and the next block 1,1,1,1 emits 0x04, 0x00.
- With MULT_ACC_PEAK_EN, products 3,200,17,9 -> bytes 0xE5, 0x00, 0xC8. Without the macro -> only 0xE5, 0x00, and the next res_valid occurs only after four new accepts.
- BLOCK_LEN=1, products 5,7 with res_ready=1 -> bytes 0x05, 0x00, 0x07, 0x00, and prod_ready is low for exactly 2 cycles per product.
